// File: rtl/pulse_bit_recover_pkg.sv
// pulse_bit_recover_pkg: shared state encodings, default timing thresholds and helpers
package pulse_bit_recover_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILTER_LEN  = 4;
  localparam int DEF_CNT_W       = 10;
  localparam int DEF_MIN_PULSE   = 8;
  localparam int DEF_ONE_MIN     = 40;
  localparam int DEF_PULSE_MAX   = 120;
  localparam int DEF_GAP_TIMEOUT = 400;
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/pulse_bit_recover_line_filter.sv
// pulse_bit_recover_line_filter: synchronises the raw line and debounces it into a clean level with edge pulses
module pulse_bit_recover_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line_in,
  output logic filtered,
  output logic rise,
  output logic fall
);
  localparam int RW = $clog2(FILTER_LEN + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [RW-1:0]          run;
  logic                   synced;
  assign synced = sync[SYNC_STAGES-1];
  // shift the synchroniser and flip the level once FILTER_LEN disagreeing samples arrive in a row
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      run      <= '0;
      filtered <= 1'b0;
      rise     <= 1'b0;
      fall     <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == filtered) run <= '0;
      else if (run == RW'(FILTER_LEN - 1)) begin
        filtered <= synced;
        rise     <= synced;
        fall     <= ~synced;
        run      <= '0;
      end else run <= run + 1'b1;
    end
  end
endmodule

// File: rtl/pulse_bit_recover.sv
// pulse_bit_recover: measures filtered high pulses into serial bits, flags frame gaps and malformed pulses
module pulse_bit_recover
  import pulse_bit_recover_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILTER_LEN  = DEF_FILTER_LEN,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MIN_PULSE   = DEF_MIN_PULSE,
  parameter int ONE_MIN     = DEF_ONE_MIN,
  parameter int PULSE_MAX   = DEF_PULSE_MAX,
  parameter int GAP_TIMEOUT = DEF_GAP_TIMEOUT
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       line_in,
  output logic       serial_data,
  output logic       serial_clock,
  output logic       frame_gap,
  output logic       pulse_error,
  output logic [7:0] error_count
);
  localparam logic [CNT_W-1:0] W_MIN = CNT_W'(MIN_PULSE);
  localparam logic [CNT_W-1:0] W_ONE = CNT_W'(ONE_MIN);
  localparam logic [CNT_W-1:0] W_MAX = CNT_W'(PULSE_MAX);
  localparam logic [CNT_W-1:0] W_GAP = CNT_W'(GAP_TIMEOUT);
  localparam logic [CNT_W-1:0] W_SAT = '1;
  if (!(SYNC_STAGES >= 2 && FILTER_LEN >= 1 && MIN_PULSE < ONE_MIN && ONE_MIN <= PULSE_MAX &&
        PULSE_MAX < (2 ** CNT_W) - 1 && GAP_TIMEOUT < 2 ** CNT_W)) begin : g_bad_params
    $error("pulse_bit_recover: illegal parameter combination");
  end
  logic             filtered;
  logic             rise;
  logic             fall;
  state_t           state;
  logic [CNT_W-1:0] count;
  pulse_bit_recover_line_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER_LEN (FILTER_LEN)
  ) u_filt (
    .clock   (clock),
    .reset_n (reset_n),
    .line_in (line_in),
    .filtered(filtered),
    .rise    (rise),
    .fall    (fall)
  );
  // pulse/gap FSM: width counter, classifier, strobes and saturating error counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      count        <= '0;
      serial_data  <= 1'b0;
      serial_clock <= 1'b0;
      frame_gap    <= 1'b0;
      pulse_error  <= 1'b0;
      error_count  <= '0;
    end else begin
      serial_clock <= 1'b0;
      frame_gap    <= 1'b0;
      pulse_error  <= 1'b0;
      case (state)
        IDLE: if (rise) begin
          state <= HIGH;
          count <= CNT_W'(1);
        end
        HIGH: if (fall) begin
          if (count < W_MIN) begin
            state <= IDLE;
            count <= '0;
          end else if (count <= W_MAX) begin
            serial_data  <= count >= W_ONE;
            serial_clock <= 1'b1;
            state        <= LOW;
            count        <= CNT_W'(1);
          end else begin
            pulse_error <= 1'b1;
            error_count <= sat_inc8(error_count);
            state       <= IDLE;
            count       <= '0;
          end
        end else if (filtered && count != W_SAT) count <= count + 1'b1;
        LOW: if (rise) begin
          frame_gap <= count == W_GAP;
          state     <= HIGH;
          count     <= CNT_W'(1);
        end else if (count == W_GAP) begin
          frame_gap <= 1'b1;
          state     <= IDLE;
          count     <= '0;
        end else count <= count + 1'b1;
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_pulse_bit_recover.sv
// tb_pulse_bit_recover: directed pulse patterns with hand-computed bits, latencies and error counts
module tb_pulse_bit_recover;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       line_in = 1'b0;
  logic       serial_data;
  logic       serial_clock;
  logic       frame_gap;
  logic       pulse_error;
  logic [7:0] error_count;
  pulse_bit_recover dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .line_in     (line_in),
    .serial_data (serial_data),
    .serial_clock(serial_clock),
    .frame_gap   (frame_gap),
    .pulse_error (pulse_error),
    .error_count (error_count)
  );
  always #5 clock = ~clock;
  int   cyc = 0;
  int   n_strobe = 0, n_gap = 0, n_err = 0, n_multi = 0, n_excl = 0, n_filt_chg = 0;
  int   last_strobe_cyc = 0, last_gap_cyc = 0, last_fall = 0;
  logic prev_sc = 1'b0, prev_filt = 1'b0;
  logic bits[$];
  int   total = 0, bad = 0;
  always @(posedge clock) cyc <= cyc + 1;
  // observe outputs 1 time unit after each edge
  always @(posedge clock) begin
    #1;
    if (serial_clock) begin
      n_strobe++;
      bits.push_back(serial_data);
      last_strobe_cyc = cyc;
      if (prev_sc) n_multi++;
    end
    if (frame_gap) begin
      n_gap++;
      last_gap_cyc = cyc;
    end
    if (pulse_error) n_err++;
    if (int'(serial_clock) + int'(frame_gap) + int'(pulse_error) > 1) n_excl++;
    if (dut.u_filt.filtered !== prev_filt) n_filt_chg++;
    prev_sc   = serial_clock;
    prev_filt = dut.u_filt.filtered;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    line_in = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(3);
  endtask
  task automatic pulse(input int w, input int low);
    line_in = 1'b1;
    tick(w);
    line_in = 1'b0;
    last_fall = cyc;
    tick(low);
  endtask
  int s, e, g;
  initial begin
    do_reset();
    check("rst_data", serial_data, 0);
    check("rst_clk", serial_clock, 0);
    check("rst_gap", frame_gap, 0);
    check("rst_err", pulse_error, 0);
    check("rst_cnt", error_count, 0);
    // 1: single short pulse
    s = n_strobe;
    pulse(20, 30);
    check("t1_strobes", n_strobe - s, 1);
    check("t1_bit", bits[s], 0);
    check("t1_latency", last_strobe_cyc - last_fall, 7);
    // 2: width boundaries around ONE_MIN and PULSE_MAX
    do_reset();
    s = n_strobe;
    e = n_err;
    pulse(39, 30);
    pulse(40, 30);
    pulse(120, 30);
    check("t2_strobes3", n_strobe - s, 3);
    check("t2_w39", bits[s], 0);
    check("t2_w40", bits[s+1], 1);
    check("t2_w120", bits[s+2], 1);
    pulse(121, 30);
    check("t2_w121_nostrobe", n_strobe - s, 3);
    check("t2_w121_err", n_err - e, 1);
    check("t2_errcnt", error_count, 1);
    // 3: spike, glitch pulse and MIN_PULSE boundary
    do_reset();
    s = n_strobe;
    e = n_err;
    g = n_filt_chg;
    pulse(3, 20);
    check("t3_spike_filt", n_filt_chg - g, 0);
    check("t3_spike_strobe", n_strobe - s, 0);
    pulse(6, 30);
    check("t3_w6_strobe", n_strobe - s, 0);
    check("t3_w6_err", n_err - e, 0);
    pulse(8, 30);
    check("t3_w8_strobe", n_strobe - s, 1);
    check("t3_w8_bit", bits[s], 0);
    // 4: frame 1,0,1,1 then idle gap
    do_reset();
    s = n_strobe;
    g = n_gap;
    pulse(60, 30);
    pulse(20, 30);
    pulse(60, 30);
    pulse(60, 500);
    check("t4_strobes", n_strobe - s, 4);
    check("t4_b0", bits[s], 1);
    check("t4_b1", bits[s+1], 0);
    check("t4_b2", bits[s+2], 1);
    check("t4_b3", bits[s+3], 1);
    check("t4_gaps", n_gap - g, 1);
    check("t4_gap_after_strobe", last_gap_cyc - last_strobe_cyc, 400);
    check("t4_gap_after_fall", last_gap_cyc - last_fall, 407);
    tick(500);
    check("t4_idle_no_regap", n_gap - g, 1);
    // 5: error counter saturation
    do_reset();
    s = n_strobe;
    e = n_err;
    for (int i = 0; i < 300; i++) pulse(122, 8);
    check("t5_errcnt_sat", error_count, 255);
    check("t5_err_pulses", n_err - e, 300);
    check("t5_no_strobe", n_strobe - s, 0);
    // 6: reset in the middle of a pulse
    do_reset();
    pulse(130, 30);
    pulse(50, 30);
    check("t6_pre_data", serial_data, 1);
    check("t6_pre_cnt", error_count, 1);
    s = n_strobe;
    e = n_err;
    line_in = 1'b1;
    tick(60);
    reset_n = 1'b0;
    #1;
    check("t6_rst_data", serial_data, 0);
    check("t6_rst_clk", serial_clock, 0);
    check("t6_rst_gap", frame_gap, 0);
    check("t6_rst_err", pulse_error, 0);
    check("t6_rst_cnt", error_count, 0);
    line_in = 1'b0;
    tick(5);
    reset_n = 1'b1;
    tick(20);
    check("t6_no_stale_strobe", n_strobe - s, 0);
    pulse(30, 30);
    check("t6_strobes", n_strobe - s, 1);
    check("t6_bit", bits[s], 0);
    check("t6_no_err", n_err - e, 0);
    check("strobe_width", n_multi, 0);
    check("exclusive_outs", n_excl, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
